// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg
// Shared types for the fabric-side I2C register-map owner.
//   bus08_t     : one byte of register data
//   regAddr_t   : byte-wide register-map address seen by fabric requesters
//   arbState_t  : arbiter FSM states, one access walks IDLE->ARB->ACCESS->RESP
package reg_bank_arbiter_pkg;

    typedef logic [7:0] bus08_t;
    typedef logic [7:0] regAddr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arbState_t;

endpackage

// File: rtl/reg_bank_arbiter_ctrl_import.sv
// ctrl_import_sync
// Imports one SCL-domain control register into the clk domain. The byte is
// double-flopped, then a counter tracks how many consecutive synced samples
// were identical. Only a value that has been stable long enough and differs
// from the current shadow is committed, with a one-cycle update strobe.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_async        : raw writeReg byte from the slave (asynchronous)
//   o_ctrl         : committed shadow value
//   o_update       : one-cycle pulse in the cycle after a commit edge
module ctrl_import_sync
    import reg_bank_arbiter_pkg::*;
#(
    parameter int STABLE_CYC = 3
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  bus08_t i_async,
    output bus08_t o_ctrl,
    output logic   o_update
);

    localparam int            CW      = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    bus08_t        r_sync1;
    bus08_t        r_sync2;
    bus08_t        r_prev;
    bus08_t        r_ctrl;
    logic [CW-1:0] r_cnt;
    logic          r_update;
    logic [CW-1:0] w_cntNext;
    logic          w_same;
    logic          w_commit;

    // Any change between consecutive synced samples restarts the count, so
    // a torn multi-bit transfer never survives long enough to commit.
    always_comb begin
        w_same    = (r_sync2 == r_prev);
        w_cntNext = '0;
        if (w_same) begin
            w_cntNext = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
        w_commit = w_same && (w_cntNext == CNT_MAX) && (r_sync2 != r_ctrl);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_ctrl   <= '0;
            r_cnt    <= '0;
            r_update <= 1'b0;
        end else begin
            r_sync1  <= i_async;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_cnt    <= w_cntNext;
            r_update <= w_commit;
            if (w_commit) begin
                r_ctrl <= r_sync2;
            end
        end
    end

    assign o_ctrl   = r_ctrl;
    assign o_update = r_update;

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
// Owns the I2C slave register map on the fabric side. NUM_REQ requesters are
// arbitrated round-robin onto a status bank (R/W, drives the slave readReg)
// and a read-only control shadow imported from the slave writeReg.
// Address map: 0..NUM_REGS-1 status, NUM_REGS..2*NUM_REGS-1 control.
// Ports:
//   i_clk, i_rst_n                         : clock, asynchronous active-low reset
//   i_req/i_reqWr/i_reqAddr/i_reqWdata     : per-requester level request + op
//   o_gnt/o_rspValid/o_rspRdata/o_rspErr   : one-hot grant with response
//   i_i2cWrReg                             : slave writeReg (SCL domain)
//   o_rdReg                                : status bank to slave readReg
//   o_ctrlReg/o_ctrlUpdate                 : committed control shadow + strobes
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 15,
    parameter int STABLE_CYC = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ-1:0]      i_reqWr,
    input  regAddr_t [NUM_REQ-1:0]  i_reqAddr,
    input  bus08_t [NUM_REQ-1:0]    i_reqWdata,
    output logic [NUM_REQ-1:0]      o_gnt,
    output logic                    o_rspValid,
    output bus08_t                  o_rspRdata,
    output logic                    o_rspErr,
    input  bus08_t [NUM_REGS-1:0]   i_i2cWrReg,
    output bus08_t [NUM_REGS-1:0]   o_rdReg,
    output bus08_t [NUM_REGS-1:0]   o_ctrlReg,
    output logic [NUM_REGS-1:0]     o_ctrlUpdate
);

    localparam int IW        = $clog2(NUM_REQ);
    localparam int CTRL_BASE = NUM_REGS;

    arbState_t             r_state;
    arbState_t             w_nextState;
    logic [IW-1:0]         r_rrPtr;
    logic [IW-1:0]         r_winIdx;
    logic                  r_wr;
    regAddr_t              r_addr;
    bus08_t                r_wdata;
    bus08_t [NUM_REGS-1:0] r_rdReg;
    bus08_t                r_rspRdata;
    logic                  r_rspErr;

    logic                  w_hiFound;
    logic                  w_loFound;
    logic [IW-1:0]         w_hiIdx;
    logic [IW-1:0]         w_loIdx;
    logic [IW-1:0]         w_winIdx;
    logic                  w_inStatus;
    logic                  w_inCtrl;
    logic                  w_err;
    bus08_t                w_statusRd;
    bus08_t                w_ctrlRd;
    bus08_t                w_rdata;
    bus08_t [NUM_REGS-1:0] w_ctrlReg;

    // One synchronizer/stability filter per control register.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrlImport
        ctrl_import_sync #(
            .STABLE_CYC (STABLE_CYC)
        ) u_ctrlImport (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_async  (i_i2cWrReg[g]),
            .o_ctrl   (w_ctrlReg[g]),
            .o_update (o_ctrlUpdate[g])
        );
    end

    // Round-robin pick: the lowest requester at or above the pointer wins,
    // otherwise wrap to the lowest requester overall.
    always_comb begin
        w_hiFound = 1'b0;
        w_loFound = 1'b0;
        w_hiIdx   = '0;
        w_loIdx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_loFound = 1'b1;
                w_loIdx   = IW'(i);
                if (IW'(i) >= r_rrPtr) begin
                    w_hiFound = 1'b1;
                    w_hiIdx   = IW'(i);
                end
            end
        end
        w_winIdx = w_hiFound ? w_hiIdx : w_loIdx;
    end

    // Decode of the latched access; the read returns the control shadow as
    // registered before any commit on the same edge.
    always_comb begin
        w_inStatus = (r_addr < regAddr_t'(NUM_REGS));
        w_inCtrl   = !w_inStatus && (r_addr < regAddr_t'(2 * NUM_REGS));
        w_err      = !(w_inStatus || w_inCtrl) || (r_wr && w_inCtrl);
        w_statusRd = '0;
        w_ctrlRd   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_addr == regAddr_t'(i)) begin
                w_statusRd = r_rdReg[i];
            end
            if (r_addr == regAddr_t'(CTRL_BASE + i)) begin
                w_ctrlRd = w_ctrlReg[i];
            end
        end
        if (w_err || r_wr) begin
            w_rdata = '0;
        end else begin
            w_rdata = w_inStatus ? w_statusRd : w_ctrlRd;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state; a requester that drops out before ARB evaluates
    // leaves nothing to grant and the FSM falls back to IDLE.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    w_nextState = (|i_req) ? ARB : IDLE;
            ARB:     w_nextState = w_loFound ? ACCESS : IDLE;
            ACCESS:  w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: grant and response exist only during RESP.
    always_comb begin
        o_gnt      = '0;
        o_rspValid = 1'b0;
        o_rspRdata = '0;
        o_rspErr   = 1'b0;
        if (r_state == RESP) begin
            o_gnt[r_winIdx] = 1'b1;
            o_rspValid      = 1'b1;
            o_rspRdata      = r_rspRdata;
            o_rspErr        = r_rspErr;
        end
    end

    // Datapath: latch the winner, perform the access, advance the pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rrPtr    <= '0;
            r_winIdx   <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdReg    <= '0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            if (r_state == ARB && w_loFound) begin
                r_winIdx <= w_winIdx;
                r_wr     <= i_reqWr[w_winIdx];
                r_addr   <= i_reqAddr[w_winIdx];
                r_wdata  <= i_reqWdata[w_winIdx];
            end
            if (r_state == ACCESS) begin
                r_rspRdata <= w_rdata;
                r_rspErr   <= w_err;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (r_wr && r_addr == regAddr_t'(i)) begin
                        r_rdReg[i] <= r_wdata;
                    end
                end
            end
            if (r_state == RESP) begin
                r_rrPtr <= (r_winIdx == IW'(NUM_REQ - 1)) ? '0 : r_winIdx + 1'b1;
            end
        end
    end

    assign o_rdReg   = r_rdReg;
    assign o_ctrlReg = w_ctrlReg;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
// Scoreboard bench for reg_bank_arbiter. Stimulus tasks compute each expected
// response from a register-map model and queue it; a monitor pops and compares
// whenever the DUT presents rsp_valid.
module tb_reg_bank_arbiter;
    import reg_bank_arbiter_pkg::*;

    localparam int NREQ  = 4;
    localparam int NREGS = 15;
    localparam int STAB  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       reqWr;
    regAddr_t [NREQ-1:0]   reqAddr;
    bus08_t [NREQ-1:0]     reqWdata;
    logic [NREQ-1:0]       gnt;
    logic                  rspValid;
    bus08_t                rspRdata;
    logic                  rspErr;
    bus08_t [NREGS-1:0]    i2cWrReg;
    bus08_t [NREGS-1:0]    rdReg;
    bus08_t [NREGS-1:0]    ctrlReg;
    logic [NREGS-1:0]      ctrlUpdate;

    typedef struct {
        int idx;
        int rdata;
        int err;
    } exp_t;

    exp_t sbQ[$];
    int   total = 0;
    int   bad   = 0;
    int   statusModel[NREGS];
    int   ctrlModel[NREGS];
    int   ctrlDrive[NREGS];
    int   expUpd[NREGS];
    int   updCount[NREGS];
    int   rrModel;
    int   stimWr[NREQ];
    int   stimAddr[NREQ];
    int   stimData[NREQ];

    reg_bank_arbiter #(
        .NUM_REQ    (NREQ),
        .NUM_REGS   (NREGS),
        .STABLE_CYC (STAB)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_reqWr      (reqWr),
        .i_reqAddr    (reqAddr),
        .i_reqWdata   (reqWdata),
        .o_gnt        (gnt),
        .o_rspValid   (rspValid),
        .o_rspRdata   (rspRdata),
        .o_rspErr     (rspErr),
        .i_i2cWrReg   (i2cWrReg),
        .o_rdReg      (rdReg),
        .o_ctrlReg    (ctrlReg),
        .o_ctrlUpdate (ctrlUpdate)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: counts update strobes and checks every response in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                updCount[i] += int'(ctrlUpdate[i]);
            end
            if (rspValid) begin
                checkOutput("sb_has_expected", int'(sbQ.size() > 0), 1);
                if (sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    checkOutput($sformatf("gnt_req%0d", e.idx), int'(gnt), 1 << e.idx);
                    checkOutput($sformatf("rdata_req%0d", e.idx), int'(rspRdata), e.rdata);
                    checkOutput($sformatf("err_req%0d", e.idx), int'(rspErr), e.err);
                end
            end else if (gnt != '0) begin
                checkOutput("gnt_without_valid", int'(gnt), 0);
            end
        end
    end

    // Reference model of one access against the register map.
    function automatic exp_t modelAccess(input int idx, input int wr, input int addr, input int data);
        exp_t e;
        e.idx   = idx;
        e.rdata = 0;
        e.err   = 0;
        if (addr >= 2 * NREGS) begin
            e.err = 1;
        end else if (addr >= NREGS) begin
            if (wr != 0) e.err = 1;
            else         e.rdata = ctrlModel[addr - NREGS];
        end else if (wr != 0) begin
            statusModel[addr] = data;
        end else begin
            e.rdata = statusModel[addr];
        end
        return e;
    endfunction

    // Queue the responses of a simultaneous request set in round-robin order.
    task automatic pushExpected(input logic [NREQ-1:0] mask);
        int last;
        last = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rrModel + k) % NREQ;
            if (mask[idx]) begin
                sbQ.push_back(modelAccess(idx, stimWr[idx], stimAddr[idx], stimData[idx]));
                last = idx;
            end
        end
        if (last >= 0) rrModel = (last + 1) % NREQ;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                reqWr[i]    = (stimWr[i] != 0);
                reqAddr[i]  = 8'(stimAddr[i]);
                reqWdata[i] = 8'(stimData[i]);
            end
        end
        req = req | mask;
    endtask

    // Drop each request in its grant cycle; optionally check latency/spacing.
    task automatic waitGrants(input logic [NREQ-1:0] mask, input bit checkTiming);
        logic [NREQ-1:0] pending;
        int n;
        int lastPos;
        pending = mask;
        n       = 0;
        lastPos = 0;
        while (pending != '0 && n < 8 * NREQ + 8) begin
            @(negedge clk);
            n++;
            if ((gnt & pending) != '0) begin
                if (checkTiming) begin
                    if (lastPos == 0) checkOutput("first_gnt_latency", n, 3);
                    else              checkOutput("gnt_spacing", n - lastPos, 4);
                end
                lastPos = n;
                req     = req & ~gnt;
                pending = pending & ~gnt;
            end
        end
        if (pending != '0) begin
            checkOutput("grant_timeout", int'(pending), 0);
            req = req & ~pending;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        sbQ.delete();
        rrModel = 0;
        for (int i = 0; i < NREGS; i++) begin
            statusModel[i] = 0;
            ctrlModel[i]   = 0;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic setCtrl();
        for (int i = 0; i < NREGS; i++) begin
            i2cWrReg[i] = 8'(ctrlDrive[i]);
            if (ctrlDrive[i] != ctrlModel[i]) expUpd[i]++;
            ctrlModel[i] = ctrlDrive[i];
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic checkBank(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            checkOutput($sformatf("%s_rdReg%0d", tag, i), int'(rdReg[i]), statusModel[i]);
            checkOutput($sformatf("%s_ctrlReg%0d", tag, i), int'(ctrlReg[i]), ctrlModel[i]);
            checkOutput($sformatf("%s_updCount%0d", tag, i), updCount[i], expUpd[i]);
        end
    endtask

    task automatic runOne(input int idx, input int wr, input int addr, input int data, input bit timing);
        logic [NREQ-1:0] mask;
        mask          = '0;
        mask[idx]     = 1'b1;
        stimWr[idx]   = wr;
        stimAddr[idx] = addr;
        stimData[idx] = data;
        pushExpected(mask);
        applyStimulus(mask);
        waitGrants(mask, timing);
    endtask

    initial begin
        int gntSeen;
        logic [NREQ-1:0] mask;
        rst_n    = 1'b0;
        req      = '0;
        reqWr    = '0;
        reqAddr  = '0;
        reqWdata = '0;
        i2cWrReg = '0;
        for (int i = 0; i < NREGS; i++) begin
            ctrlDrive[i] = 0;
            expUpd[i]    = 0;
            updCount[i]  = 0;
        end
        @(negedge clk);
        applyReset();
        checkOutput("reset_rspValid", int'(rspValid), 0);
        checkOutput("reset_gnt", int'(gnt), 0);
        checkBank("reset");

        // Single write, uncontended: grant three clocks after the request.
        runOne(1, 1, 2, 'hA5, 1'b1);
        checkBank("t1");

        // All four read at once: grants 0,1,2,3 four clocks apart, twice.
        applyReset();
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < NREQ; i++) begin
                stimWr[i]   = 0;
                stimAddr[i] = 0;
                stimData[i] = 0;
            end
            pushExpected(4'b1111);
            applyStimulus(4'b1111);
            waitGrants(4'b1111, 1'b1);
        end

        // Control import: held value commits within 2+STABLE_CYC clocks.
        i2cWrReg[5] = 8'h3C;
        repeat (2 + STAB) @(negedge clk);
        checkOutput("ctrl5_commit_time", int'(ctrlReg[5]), 'h3C);
        ctrlDrive[5] = 'h3C;
        ctrlModel[5] = 'h3C;
        expUpd[5]++;
        repeat (8) @(negedge clk);
        // Toggling every clock must never commit.
        for (int k = 0; k < 20; k++) begin
            i2cWrReg[7] = (k % 2 == 1) ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        i2cWrReg[7] = 8'h00;
        repeat (10) @(negedge clk);
        checkBank("t3");

        // Control-range read, control-range write error, out-of-map read.
        runOne(0, 0, NREGS + 5, 0, 1'b1);
        runOne(0, 1, NREGS + 5, 'h11, 1'b0);
        runOne(2, 0, 'h40, 0, 1'b0);
        checkBank("t4");

        // Requester drops in the ARB cycle: no grant, pointer unchanged.
        stimWr[2] = 0; stimAddr[2] = 0; stimData[2] = 0;
        applyStimulus(4'b0100);
        @(negedge clk);
        req[2]  = 1'b0;
        gntSeen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (gnt != '0) gntSeen++;
        end
        checkOutput("drop_no_gnt", gntSeen, 0);
        for (int i = 0; i < NREQ; i++) begin
            stimWr[i] = 0; stimAddr[i] = i; stimData[i] = 0;
        end
        pushExpected(4'b1111);
        applyStimulus(4'b1111);
        waitGrants(4'b1111, 1'b1);

        // Randomized traffic with occasional control updates.
        for (int it = 0; it < 40; it++) begin
            if (it % 8 == 0) begin
                for (int i = 0; i < NREGS; i++) begin
                    if ($urandom_range(0, 2) == 0) ctrlDrive[i] = int'($urandom_range(0, 255));
                end
                setCtrl();
            end
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                int r;
                r           = int'($urandom_range(0, 9));
                stimWr[i]   = int'($urandom_range(0, 1));
                stimData[i] = int'($urandom_range(0, 255));
                if (r < 6)       stimAddr[i] = int'($urandom_range(0, NREGS - 1));
                else if (r < 8)  stimAddr[i] = int'($urandom_range(NREGS, 2 * NREGS - 1));
                else if (r == 8) stimAddr[i] = int'($urandom_range(2 * NREGS, 255));
                else             stimAddr[i] = 'h40;
            end
            pushExpected(mask);
            applyStimulus(mask);
            waitGrants(mask, 1'b0);
        end
        checkBank("rand");

        // Reset during ACCESS of a write: abandoned, then grant from pointer 0.
        for (int i = 0; i < NREGS; i++) ctrlDrive[i] = 0;
        setCtrl();
        stimWr[1] = 1; stimAddr[1] = 1; stimData[1] = 'h7E;
        stimWr[3] = 0; stimAddr[3] = 1; stimData[3] = 0;
        applyStimulus(4'b1010);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_gnt", int'(gnt), 0);
        checkOutput("rst_mid_rdReg1", int'(rdReg[1]), 0);
        repeat (2) @(negedge clk);
        sbQ.delete();
        rrModel = 0;
        for (int i = 0; i < NREGS; i++) begin
            statusModel[i] = 0;
            ctrlModel[i]   = 0;
        end
        rst_n = 1'b1;
        pushExpected(4'b1010);
        waitGrants(4'b1010, 1'b1);
        checkBank("t5");

        checkOutput("sb_drained", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
